// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate exerciser family.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Truth tables indexed by {a,b}: bit 0 is the output for 00, bit 3 for 11.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam int unsigned VEC_COUNT = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned CNT_W     = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

  // Presentation order of {a,b} vectors; slot k holds the vector for index k.
  localparam logic [2*VEC_COUNT-1:0] VEC_ORDER = {2'b11, 2'b10, 2'b01, 2'b00};

  function automatic logic [1:0] vec_at(input logic [IDX_W-1:0] idx);
    return VEC_ORDER[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter with a terminal flag that is high on the final count.
module settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         term_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero load terminates immediately rather than stalling forever.
  assign term_c = (cnt_q <= W'(1));

endmodule

// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through 00,01,10,11, samples after a settle time and
// reports error count, first failing vector and pass/done.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter logic [3:0]  TRUTH  = TT_OR,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  state_e           state_q,      state_d;
  logic [IDX_W-1:0] idx_q,        idx_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [ERR_W-1:0] err_q,        err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q,   fail_vec_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_term_c;
  logic [WIDTH-1:0] expect_c;
  logic             mismatch_c;
  logic [IDX_W-1:0] nxt_idx_c;
  logic [1:0]       nxt_vec_c;
  logic [1:0]       cur_vec_c;

  settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .dec      (tmr_dec),
    .term_c   (tmr_term_c)
  );

  assign cur_vec_c  = vec_at(idx_q);
  assign nxt_idx_c  = idx_q + IDX_W'(1);
  assign nxt_vec_c  = vec_at(nxt_idx_c);
  assign expect_c   = {WIDTH{TRUTH[cur_vec_c]}};
  assign mismatch_c = |(y_in ^ expect_c);

  // Next-state, stimulus and result-register update.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = DRIVE;
          idx_d        = '0;
          a_d          = '0;
          b_d          = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          tmr_load     = 1'b1;
        end
      end
      DRIVE: begin
        if (tmr_term_c) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch_c) begin
          err_d = err_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = cur_vec_c;
          end
        end
        if (idx_q != LAST_IDX) begin
          state_d  = DRIVE;
          idx_d    = nxt_idx_c;
          a_d      = {WIDTH{nxt_vec_c[1]}};
          b_d      = {WIDTH{nxt_vec_c[0]}};
          tmr_load = 1'b1;
        end else begin
          state_d = DONE;
          a_d     = '0;
          b_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign pass       = done_q && (err_q == '0);

endmodule
